// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   mdu_op_e  - MDUOP operation codes, also used by the control decoder.
//   rd_sel_e  - ReadHILO read-select codes.
//   MULT_TIME / DIV_TIME - default busy latencies supplied on Time.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_HI   = 2'd1,
        RD_LO   = 2'd2
    } rd_sel_e;

    localparam int unsigned MULT_TIME = 5;
    localparam int unsigned DIV_TIME  = 10;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage control/operand bundle for mdu_core.
//   Start, MDUOP, A, B, Time, ReadHILO : driven by the pipeline (master)
//   Busy, HILOOut                      : driven by mdu_core (slave)
interface mdu_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic              Start;
    logic [3:0]        MDUOP;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [CNT_W-1:0]  Time;
    logic [1:0]        ReadHILO;
    logic              Busy;
    logic [DATA_W-1:0] HILOOut;

    modport master (
        output Start, MDUOP, A, B, Time, ReadHILO,
        input  Busy, HILOOut
    );

    modport slave (
        input  Start, MDUOP, A, B, Time, ReadHILO,
        output Busy, HILOOut
    );
endinterface

// File: rtl/mdu_latency_ctr.sv
// mdu_latency_ctr: busy-window counter for multi-cycle MDU operations.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : launch of a MULT/MULTU/DIV/DIVU (caller gates with !busy_o)
//   time_i     : number of busy cycles
//   busy_o     : counter nonzero
//   commit_o   : the coming edge writes the pending result to HI/LO
module mdu_latency_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] time_i,
    output logic             busy_o,
    output logic             commit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Set for one cycle after a zero-latency launch so it still commits
    // on the following edge without ever raising busy.
    logic             zero_q, zero_d;

    always_comb begin
        cnt_d  = cnt_q;
        zero_d = 1'b0;
        if (load_i) begin
            cnt_d  = time_i;
            zero_d = (time_i == '0);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign busy_o   = (cnt_q != '0);
    assign commit_o = (cnt_q == CNT_W'(1)) || zero_q;

endmodule

// File: rtl/mdu_core.sv
// mdu_core: E-stage multiply/divide unit owning the architectural HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mdu_if.slave (Start, MDUOP, A, B, Time, ReadHILO in;
//                Busy, HILOOut out)
// The result is computed at the Start edge into pending registers and
// written to HI/LO when the latency counter expires.
// Build option MDU_DIV0_KEEP_EN: divide by zero leaves HI/LO untouched
// at commit instead of writing LO=all-ones, HI=A.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);

    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic                accept, load, commit, commit_wr;
    logic                b_zero, s_ovf;
    logic [DATA_W-1:0]   divisor;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   quo_s, rem_s, quo_u, rem_u;

    // Start while Busy is illegal upstream; it is simply dropped here.
    assign accept = bus.Start && !bus.Busy;

    assign b_zero  = (bus.B == '0);
    assign s_ovf   = (bus.A == SMIN) && (bus.B == '1);
    // Substitute divisor keeps the dividers free of x when B is zero.
    assign divisor = b_zero ? DATA_W'(1) : bus.B;

    assign prod_s = $signed(bus.A) * $signed(bus.B);
    assign prod_u = bus.A * bus.B;
    assign quo_s  = $signed(bus.A) / $signed(divisor);
    assign rem_s  = $signed(bus.A) % $signed(divisor);
    assign quo_u  = bus.A / divisor;
    assign rem_u  = bus.A % divisor;

    mdu_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .time_i   (bus.Time),
        .busy_o   (bus.Busy),
        .commit_o (commit)
    );

`ifdef MDU_DIV0_KEEP_EN
    logic keep_q, keep_d;

    always_comb begin
        keep_d = keep_q;
        if (accept) begin
            case (bus.MDUOP)
                MULT, MULTU: keep_d = 1'b0;
                DIV, DIVU:   keep_d = b_zero;
                default:     keep_d = keep_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) keep_q <= 1'b0;
        else       keep_q <= keep_d;
    end

    assign commit_wr = commit && !keep_q;
`else
    assign commit_wr = commit;
`endif

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        load      = 1'b0;
        if (commit_wr) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end
        if (accept) begin
            case (bus.MDUOP)
                MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    load = 1'b1;
                end
                MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    load = 1'b1;
                end
                DIV: begin
                    load = 1'b1;
                    if (b_zero) begin
                        pend_lo_d = '1;
                        pend_hi_d = bus.A;
                    end else if (s_ovf) begin
                        pend_lo_d = SMIN;
                        pend_hi_d = '0;
                    end else begin
                        pend_lo_d = quo_s;
                        pend_hi_d = rem_s;
                    end
                end
                DIVU: begin
                    load = 1'b1;
                    if (b_zero) begin
                        pend_lo_d = '1;
                        pend_hi_d = bus.A;
                    end else begin
                        pend_lo_d = quo_u;
                        pend_hi_d = rem_u;
                    end
                end
                MTHI:    hi_d = bus.A;
                MTLO:    lo_d = bus.A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        case (bus.ReadHILO)
            RD_HI:   bus.HILOOut = hi_q;
            RD_LO:   bus.HILOOut = lo_q;
            default: bus.HILOOut = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: self-checking bench for mdu_core. A behavioural HI/LO model
// computed with plain integer arithmetic predicts results; busy windows and
// read-port behaviour are checked per scenario.
module tb_mdu_core;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if #(.DATA_W(32), .CNT_W(4)) bus ();

    mdu_core #(.DATA_W(32), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk)
        assert (!(bus.Start && bus.Busy)) else $error("illegal Start while Busy");

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Reference model: architectural effect of one accepted operation.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sp;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd1: begin sp = longint'(sa) * longint'(sb); p = sp; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3, 4'd4: begin
                if (b == 32'd0) begin
`ifndef MDU_DIV0_KEEP_EN
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
`endif
                end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else if (op == 4'd3) begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Launch one op, count busy cycles, track whether LO read stayed put while busy.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, output int busy_cycles, output bit stable);
        logic [31:0] pre;
        @(negedge clk);
        bus.ReadHILO = 2'd2;
        bus.MDUOP = op; bus.A = a; bus.B = b; bus.Time = t; bus.Start = 1'b1;
        #1 pre = bus.HILOOut;
        @(negedge clk);
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        busy_cycles = 0;
        stable = 1'b1;
        while (bus.Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (bus.HILOOut !== pre) stable = 1'b0;
            @(negedge clk);
        end
        if (busy_cycles == 0) @(negedge clk);
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.ReadHILO = 2'd1; #1 h = bus.HILOOut;
        bus.ReadHILO = 2'd2; #1 l = bus.HILOOut;
        bus.ReadHILO = 2'd0;
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        reset = 1'b1;
        bus.Start = 1'b0; bus.MDUOP = 4'd0; bus.A = '0; bus.B = '0; bus.Time = '0; bus.ReadHILO = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        read_hilo(h, l);
        tests++; if (h !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", h); end
        tests++; if (l !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", l); end
    endtask

    // Shared body for directed op scenarios; comparisons inline here.
    task automatic test_op(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t);
        int bc; bit st; logic [31:0] h, l; int want_bc;
        want_bc = (op >= 4'd1 && op <= 4'd4) ? int'(t) : 0;
        model_op(op, a, b);
        do_op(op, a, b, t, bc, st);
        read_hilo(h, l);
        tests++; if (bc !== want_bc) begin fails++; $display("FAIL %s_busy got %0d want %0d", name, bc, want_bc); end
        tests++; if (st !== 1'b1) begin fails++; $display("FAIL %s_hold got changed want stable", name); end
        tests++; if (h !== m_hi) begin fails++; $display("FAIL %s_hi got %h want %h", name, h, m_hi); end
        tests++; if (l !== m_lo) begin fails++; $display("FAIL %s_lo got %h want %h", name, l, m_lo); end
    endtask

    task automatic test_mult;
        test_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd7, 4'd5);
        test_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'd2, 4'd5);
    endtask

    task automatic test_div;
        test_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 4'd10);
        test_op("divu", 4'd4, 32'd7, 32'd2, 4'd10);
        test_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
    endtask

    task automatic test_div0;
        test_op("mthi_pre", 4'd5, 32'h0000_00AA, 32'd0, 4'd0);
        test_op("mtlo_pre", 4'd6, 32'h0000_00BB, 32'd0, 4'd0);
        test_op("div0", 4'd3, 32'd5, 32'd0, 4'd10);
        test_op("divu0", 4'd4, 32'h8000_0001, 32'd0, 4'd3);
    endtask

    task automatic test_mtx;
        logic [31:0] v;
        test_op("mtlo", 4'd6, 32'h0000_1234, 32'd0, 4'd5);
        test_op("mthi", 4'd5, 32'd9, 32'd0, 4'd5);
        bus.ReadHILO = 2'd3; #1 v = bus.HILOOut; bus.ReadHILO = 2'd0;
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL rd_sel3 got %h want 0", v); end
        #1 v = bus.HILOOut;
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL rd_sel0 got %h want 0", v); end
    endtask

    task automatic test_noop;
        test_op("nop", 4'd0, 32'h1111_1111, 32'd3, 4'd5);
        test_op("undef", 4'd9, 32'h2222_2222, 32'd3, 4'd5);
    endtask

    task automatic test_time0;
        test_op("mult_t0", 4'd1, 32'd1234, 32'd5678, 4'd0);
        test_op("divu_t0", 4'd4, 32'd1000, 32'd7, 4'd0);
    endtask

    task automatic test_random;
        logic [3:0] op, t;
        logic [31:0] a, b;
        int r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) op = 4'(r + 1);
            else if (r == 6) op = 4'd0;
            else op = 4'($urandom_range(7, 15));
            a = $urandom; b = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 9));
            t = 4'($urandom_range(0, 15));
            test_op("rand", op, a, b, t);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        test_op("rst_pre_hi", 4'd5, 32'hDEAD_0001, 32'd0, 4'd0);
        test_op("rst_pre_lo", 4'd6, 32'hBEEF_0002, 32'd0, 4'd0);
        @(negedge clk);
        bus.MDUOP = 4'd1; bus.A = 32'd123; bus.B = 32'd456; bus.Time = 4'd5; bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        repeat (2) @(negedge clk);
        tests++; if (bus.Busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy3 got %b want 1", bus.Busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.Busy); end
        read_hilo(h, l);
        tests++; if (h !== m_hi || l !== m_lo) begin fails++; $display("FAIL rstmid_hilo got %h/%h want %h/%h", h, l, m_hi, m_lo); end
        repeat (8) @(negedge clk);
        read_hilo(h, l);
        tests++; if (h !== m_hi || l !== m_lo) begin fails++; $display("FAIL rstmid_nocommit got %h/%h want %h/%h", h, l, m_hi, m_lo); end
        tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle got %b want 0", bus.Busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_mtx();
        test_noop();
        test_time0();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
